// File: rtl/conv_encoder_sys.sv
// Rate-1/2 convolutional encoder with per-frame constraint length K = 3..6.
// Each frame is FRAME_LEN symbols: data symbols followed by K-1 zero-flush tail symbols.
module conv_encoder_sys #(
    parameter int unsigned FRAME_LEN = 15,
    parameter int unsigned MAX_K     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] choose_constraint_length,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] encoded_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    localparam int unsigned SrW  = MAX_K - 1;
    localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StFlush,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [SrW-1:0]  sr_q, sr_d;
    logic [CntW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]      k_q, k_d;
    logic [1:0]      enc_q, enc_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic             slot_free;
    logic             frame_start;
    logic             data_fire;
    logic             flush_fire;
    logic             emit;
    logic             cur_bit;
    logic [2:0]       k_sel;
    logic [MAX_K-1:0] poly0;
    logic [MAX_K-1:0] poly1;
    logic [MAX_K-1:0] window;
    logic [SrW-1:0]   sr_shift;
    logic             g0;
    logic             g1;
    logic [CntW-1:0]  data_last_idx;
    logic [CntW-1:0]  frame_last_idx;

    assign slot_free = !out_valid_q || out_ready;

    // Unsupported K selections fall back to K=3.
    always_comb begin
        k_sel = 3'd3;
        case (choose_constraint_length)
            3'd3, 3'd4, 3'd5, 3'd6: k_sel = choose_constraint_length;
            default:                k_sel = 3'd3;
        endcase
    end

    // Generator taps: MSB multiplies the current input, LSB the oldest stored bit.
    always_comb begin
        poly0 = MAX_K'(6'o07);
        poly1 = MAX_K'(6'o05);
        case (k_q)
            3'd4: begin
                poly0 = MAX_K'(6'o15);
                poly1 = MAX_K'(6'o17);
            end
            3'd5: begin
                poly0 = MAX_K'(6'o23);
                poly1 = MAX_K'(6'o35);
            end
            3'd6: begin
                poly0 = MAX_K'(6'o53);
                poly1 = MAX_K'(6'o75);
            end
            default: begin
                poly0 = MAX_K'(6'o07);
                poly1 = MAX_K'(6'o05);
            end
        endcase
    end

    // Bits of sr above K-2 are always zero, so the window is the current bit at
    // position K-1 OR-ed over the whole register.
    assign cur_bit  = (state_q == StData) && in_bit;
    assign window   = (MAX_K'(cur_bit) << (k_q - 3'd1)) | MAX_K'(sr_q);
    assign sr_shift = (sr_q >> 1) | (SrW'(cur_bit) << (k_q - 3'd2));
    assign g0       = ^(window & poly0);
    assign g1       = ^(window & poly1);

    assign data_last_idx  = CntW'(FRAME_LEN) - CntW'(k_q);
    assign frame_last_idx = CntW'(FRAME_LEN - 1);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StData;
            StData:  if (data_fire && (sym_cnt_q == data_last_idx)) state_d = StFlush;
            StFlush: if (flush_fire && (sym_cnt_q == frame_last_idx)) state_d = StDrain;
            StDrain: if (out_valid_q && out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and per-state strobes
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b1;
        frame_start = 1'b0;
        flush_fire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy        = 1'b0;
                frame_start = start;
            end
            StData:  in_ready = slot_free;
            StFlush: flush_fire = slot_free;
            StDrain: busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    assign data_fire = in_valid && in_ready;
    assign emit      = data_fire || flush_fire;

    // Datapath next state; a stalled slot leaves sr, count and output untouched.
    always_comb begin
        sr_d        = sr_q;
        sym_cnt_d   = sym_cnt_q;
        k_d         = k_q;
        enc_d       = enc_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (frame_start) begin
            k_d       = k_sel;
            sr_d      = '0;
            sym_cnt_d = '0;
        end else if (emit) begin
            sr_d        = sr_shift;
            sym_cnt_d   = sym_cnt_q + CntW'(1);
            enc_d       = {g0, g1};
            out_valid_d = 1'b1;
            out_last_d  = (sym_cnt_q == frame_last_idx);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            sym_cnt_q   <= '0;
            k_q         <= 3'd3;
            enc_q       <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            sym_cnt_q   <= sym_cnt_d;
            k_q         <= k_d;
            enc_q       <= enc_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign encoded_bits = enc_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Scoreboard bench for conv_encoder_sys: expected frames come from a convolution model
// of the generator polynomials; a negedge monitor pops and compares on each handshake.
module tb_conv_encoder_sys;

    localparam int FRAME_LEN = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] choose = 3'd3;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [1:0] encoded_bits;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    always #5 clk = ~clk;

    conv_encoder_sys #(
        .FRAME_LEN(FRAME_LEN),
        .MAX_K    (6)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .choose_constraint_length(choose),
        .in_bit                  (in_bit),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .encoded_bits            (encoded_bits),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_last                (out_last),
        .busy                    (busy)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] exp_q[$];  // {last, g0, g1}
    bit         data_q[$];
    int         pops_in_frame = 0;
    int         stall_cnt = 0;
    bit         bp_mode = 0;
    bit         iv_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_k(input logic [2:0] sel);
        if (sel >= 3'd3 && sel <= 3'd6) return int'(sel);
        return 3;
    endfunction

    function automatic int poly(input int k, input int which);
        case (k)
            4:       return (which == 0) ? 'o15 : 'o17;
            5:       return (which == 0) ? 'o23 : 'o35;
            6:       return (which == 0) ? 'o53 : 'o75;
            default: return (which == 0) ? 'o7 : 'o5;
        endcase
    endfunction

    // Symbol t = XOR over taps j of poly[K-1-j] * u[t-j], u = data followed by K-1 zeros.
    task automatic push_model(input int k, input bit dat[$]);
        bit u[$];
        int g0;
        int g1;
        u = dat;
        repeat (k - 1) u.push_back(1'b0);
        for (int t = 0; t < FRAME_LEN; t++) begin
            g0 = 0;
            g1 = 0;
            for (int j = 0; j < k; j++) begin
                if (t - j >= 0 && u[t-j]) begin
                    g0 ^= (poly(k, 0) >> (k - 1 - j)) & 1;
                    g1 ^= (poly(k, 1) >> (k - 1 - j)) & 1;
                end
            end
            exp_q.push_back({(t == FRAME_LEN - 1) ? 1'b1 : 1'b0, g0[0], g1[0]});
        end
    endtask

    task automatic push_lit(input logic [1:0] syms[$]);
        foreach (syms[i]) exp_q.push_back({(i == FRAME_LEN - 1) ? 1'b1 : 1'b0, syms[i]});
    endtask

    // ---------------- input / ready driver ----------------
    always begin
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = bp_mode ? ($urandom_range(0, 99) < 55) : 1'b1;
        end
        in_valid = (data_q.size() > 0) && (iv_mode ? ($urandom_range(0, 99) < 70) : 1'b1);
        in_bit   = (data_q.size() > 0) ? data_q[0] : 1'b0;
        @(negedge clk);
        if (in_valid && in_ready && data_q.size() > 0) void'(data_q.pop_front());
    end

    // ---------------- monitor ----------------
    logic       hold_v = 1'b0;
    logic [1:0] hold_bits;
    logic       hold_last;
    bit         last_seen = 0;

    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst_n) begin
            hold_v    = 1'b0;
            last_seen = 0;
        end else begin
            if (last_seen) begin
                chk("busy_after_last", busy, 1'b0);
                chk("valid_after_last", out_valid, 1'b0);
                last_seen = 0;
            end
            if (hold_v) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_bits", encoded_bits, hold_bits);
                chk("stall_last", out_last, hold_last);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 1'b0);
                hold_v    = 1'b1;
                hold_bits = encoded_bits;
                hold_last = out_last;
            end else begin
                hold_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_symbol", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("sym[%0d]", pops_in_frame), encoded_bits, e[1:0]);
                    chk($sformatf("last[%0d]", pops_in_frame), out_last, e[2]);
                    pops_in_frame++;
                    if (e[2]) last_seen = 1;
                end
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        data_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic start_frame(input logic [2:0] sel, input bit dat[$]);
        @(posedge clk);
        #1;
        start         = 1'b1;
        choose        = sel;
        pops_in_frame = 0;
        foreach (dat[i]) data_q.push_back(dat[i]);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame(input bit scramble, input bit do_stall);
        int cyc = 0;
        bit stalled = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            if (scramble) begin
                if (exp_q.size() > 3) begin
                    start  = $urandom_range(0, 1);
                    choose = 3'($urandom_range(0, 7));
                end else begin
                    start = 1'b0;
                end
            end
            if (do_stall && !stalled && pops_in_frame >= 4) begin
                stall_cnt = 3;
                stalled   = 1;
            end
            cyc++;
            if (cyc > 400) begin
                chk("frame_complete", 1'b0, 1'b1);
                start = 1'b0;
                apply_reset();
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic rand_frame(input logic [2:0] sel, input bit scramble);
        bit d[$];
        int k;
        k = eff_k(sel);
        for (int i = 0; i < FRAME_LEN - k + 1; i++) d.push_back(1'($urandom_range(0, 1)));
        push_model(k, d);
        start_frame(sel, d);
        wait_frame(scramble, 0);
    endtask

    initial begin
        bit         d[$];
        bit         t1_data[$];
        logic [1:0] t1_syms[$];
        logic [1:0] t2_syms[$];
        int         cyc;

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_bits", encoded_bits, 2'b00);
        chk("rst_last", out_last, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_in_ready", in_ready, 1'b0);

        // K=3 known sequence, full throughput
        t1_data = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        t1_syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00,
                    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        push_lit(t1_syms);
        start_frame(3'd3, t1_data);
        wait_frame(0, 0);

        // K=6 impulse response
        d = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        t2_syms = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00,
                    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        push_lit(t2_syms);
        start_frame(3'd6, d);
        wait_frame(0, 0);

        // Out-of-range K select behaves as K=3
        push_lit(t1_syms);
        start_frame(3'd7, t1_data);
        wait_frame(0, 0);

        // Three-cycle output stall mid-frame
        d.delete();
        for (int i = 0; i < FRAME_LEN - 2; i++) d.push_back(1'($urandom_range(0, 1)));
        push_model(3, d);
        start_frame(3'd3, d);
        wait_frame(0, 1);

        // Reset mid-frame, then a fresh frame
        d.delete();
        for (int i = 0; i < FRAME_LEN - 3; i++) d.push_back(1'($urandom_range(0, 1)));
        push_model(4, d);
        start_frame(3'd4, d);
        cyc = 0;
        while (pops_in_frame < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_sym6", (pops_in_frame >= 6) ? 1'b1 : 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_last", out_last, 1'b0);
        exp_q.delete();
        data_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_out_valid", out_valid, 1'b0);
        chk("postrst_busy", busy, 1'b0);
        rand_frame(3'd5, 0);

        // start and K select toggled during the frame must be ignored
        rand_frame(3'd6, 1);
        rand_frame(3'd3, 1);

        // Randomized frames with back-pressure and input gaps
        for (int f = 0; f < 30; f++) begin
            bp_mode = 1'($urandom_range(0, 1));
            iv_mode = 1'($urandom_range(0, 1));
            rand_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        bp_mode = 0;
        iv_mode = 0;
        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks,
                 n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
